// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, frame size, common keyboard
// commands and the odd-parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RELEASE,
    ST_SHIFT,
    ST_ACK
  } ps2_state_e;

  localparam int FRAME_BITS = 11;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ECHO     = 8'hEE;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioning: 2-flop synchronisers on both lines, a stability filter
// on the clock and a one-cycle strobe on each filtered clock fall.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clk_raw,
  input  logic data_raw,
  output logic clk_filt,
  output logic clk_fall,
  output logic data_sync
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

  logic          clk_s1, clk_s2;
  logic          data_s1;
  logic [CW-1:0] cnt;

  // Idle lines float high, so everything resets to 1 to avoid a false fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1    <= 1'b1;
      clk_s2    <= 1'b1;
      data_s1   <= 1'b1;
      data_sync <= 1'b1;
      clk_filt  <= 1'b1;
      clk_fall  <= 1'b0;
      cnt       <= '0;
    end else begin
      clk_s1    <= clk_raw;
      clk_s2    <= clk_s1;
      data_s1   <= data_raw;
      data_sync <= data_s1;
      clk_fall  <= 1'b0;
      if (clk_s2 == clk_filt) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        clk_filt <= clk_s2;
        clk_fall <= clk_filt;
        cnt      <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 byte transmitter driving open-drain clock/data enables.
// Optional macro PS2_TX_RETRY_EN: up to two automatic retries and a RETRY_COUNT port.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_READY,
  output logic       TX_DONE,
  output logic       TX_ERROR,
  output logic       BUSY,
  input  logic       PS2_CLK_IN,
  input  logic       PS2_DATA_IN,
  output logic       PS2_CLK_OE,
  output logic       PS2_DATA_OE,
  output ps2_state_e STATE
`ifdef PS2_TX_RETRY_EN
  ,
  output logic [1:0] RETRY_COUNT
`endif
);

  localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    STOP_IDX = 4'(FRAME_BITS - 2);
  localparam logic          START_NOW = (INHIBIT_CYCLES == 1);

  ps2_state_e            state, state_n;
  logic [IW-1:0]         inh_cnt, inh_n;
  logic [TW-1:0]         tmo_cnt, tmo_n;
  logic [3:0]            bit_cnt, bit_n;
  logic [FRAME_BITS-2:0] shreg, shreg_n;
  logic                  clk_oe, clk_oe_n, data_oe, data_oe_n;
  logic                  done_q, done_n, error_q, error_n;
  logic                  fail;
  logic                  clk_filt, clk_fall, data_sync;
  logic                  accept;
`ifdef PS2_TX_RETRY_EN
  logic [1:0]            retry_cnt, retry_n;
`endif

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk       (CLK),
    .reset     (RESET),
    .clk_raw   (PS2_CLK_IN),
    .data_raw  (PS2_DATA_IN),
    .clk_filt  (clk_filt),
    .clk_fall  (clk_fall),
    .data_sync (data_sync)
  );

  // Handshake: a byte transfers on a rising CLK where TX_VALID and TX_READY are
  // both high; TX_READY drops while busy, so requests then are simply dropped.
  assign TX_READY = (state == ST_IDLE) && clk_filt && !RESET;
  assign accept   = TX_VALID && TX_READY;

  always_comb begin
    state_n   = state;
    inh_n     = inh_cnt;
    tmo_n     = tmo_cnt;
    bit_n     = bit_cnt;
    shreg_n   = shreg;
    clk_oe_n  = clk_oe;
    data_oe_n = data_oe;
    done_n    = 1'b0;
    error_n   = 1'b0;
    fail      = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_n   = retry_cnt;
`endif
    case (state)
      ST_IDLE: begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        if (accept) begin
          shreg_n   = {1'b1, odd_parity(TX_DATA), TX_DATA};
          inh_n     = '0;
          clk_oe_n  = 1'b1;
          data_oe_n = START_NOW;
          state_n   = ST_INHIBIT;
`ifdef PS2_TX_RETRY_EN
          retry_n   = 2'd0;
`endif
        end
      end
      ST_INHIBIT: begin
        if (inh_cnt == INH_LAST) begin
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b1;
          bit_n     = '0;
          tmo_n     = '0;
          state_n   = ST_RELEASE;
        end else begin
          inh_n     = inh_cnt + 1'b1;
          data_oe_n = (inh_n == INH_LAST);
        end
      end
      default: begin
        // RELEASE, SHIFT and ACK share the timeout; it beats a coincident fall.
        tmo_n = tmo_cnt + 1'b1;
        if (tmo_cnt == TMO_LAST) begin
          fail = 1'b1;
        end else if (clk_fall) begin
          if (state == ST_RELEASE) begin
            data_oe_n = ~shreg[0];
            bit_n     = 4'd1;
            state_n   = ST_SHIFT;
          end else if (state == ST_SHIFT) begin
            data_oe_n = ~shreg[bit_cnt];
            bit_n     = bit_cnt + 1'b1;
            if (bit_cnt == STOP_IDX) state_n = ST_ACK;
          end else if (data_sync) begin
            fail = 1'b1;
          end else begin
            done_n  = 1'b1;
            state_n = ST_IDLE;
          end
        end
      end
    endcase

    if (fail) begin
      clk_oe_n  = 1'b0;
      data_oe_n = 1'b0;
      error_n   = 1'b1;
      state_n   = ST_IDLE;
`ifdef PS2_TX_RETRY_EN
      if (retry_cnt != 2'd2) begin
        retry_n   = retry_cnt + 1'b1;
        error_n   = 1'b0;
        inh_n     = '0;
        clk_oe_n  = 1'b1;
        data_oe_n = START_NOW;
        state_n   = ST_INHIBIT;
      end
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= ST_IDLE;
      inh_cnt <= '0;
      tmo_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      clk_oe  <= 1'b0;
      data_oe <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_cnt <= 2'd0;
`endif
    end else begin
      state   <= state_n;
      inh_cnt <= inh_n;
      tmo_cnt <= tmo_n;
      bit_cnt <= bit_n;
      shreg   <= shreg_n;
      clk_oe  <= clk_oe_n;
      data_oe <= data_oe_n;
      done_q  <= done_n;
      error_q <= error_n;
`ifdef PS2_TX_RETRY_EN
      retry_cnt <= retry_n;
`endif
    end
  end

  assign TX_DONE     = done_q;
  assign TX_ERROR    = error_q;
  assign BUSY        = (state != ST_IDLE);
  assign PS2_CLK_OE  = clk_oe;
  assign PS2_DATA_OE = data_oe;
  assign STATE       = state;
`ifdef PS2_TX_RETRY_EN
  assign RETRY_COUNT = retry_cnt;
`endif

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain line model, a behavioural keyboard that clocks
// frames and ACKs/NACKs, and queues of expected frames and result pulses.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 100;
  localparam int TMO  = 2000;
  localparam int FLT  = 8;
  localparam int HALF = 20;
`ifdef PS2_TX_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif

  localparam logic [1:0] RES_DONE = 2'b01;
  localparam logic [1:0] RES_ERR  = 2'b10;

  // Frames as sampled by the keyboard, bit 0 = start; parity bits hand-computed.
  localparam logic [10:0] FR_ED = {1'b1, 1'b1, 8'hED, 1'b0};
  localparam logic [10:0] FR_07 = {1'b1, 1'b0, 8'h07, 1'b0};
  localparam logic [10:0] FR_00 = {1'b1, 1'b1, 8'h00, 1'b0};
  localparam logic [10:0] FR_01 = {1'b1, 1'b0, 8'h01, 1'b0};
  localparam logic [10:0] FR_EE = {1'b1, 1'b1, 8'hEE, 1'b0};

  logic       clk, reset;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready, tx_done, tx_error, busy;
  logic       clk_oe, data_oe;
  logic       dev_clk_low, dev_data_low;
  logic       clk_line, data_line;
  ps2_state_e state_dbg;
`ifdef PS2_TX_RETRY_EN
  logic [1:0] retry_count;
`endif

  int total = 0;
  int bad   = 0;
  logic [1:0]  exp_res_q[$];
  logic [10:0] exp_frame_q[$];
  logic        busy_prev = 1'b0;

  assign clk_line  = ~(clk_oe | dev_clk_low);
  assign data_line = ~(data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(FLT)) dut (
    .CLK         (clk),
    .RESET       (reset),
    .TX_DATA     (tx_data),
    .TX_VALID    (tx_valid),
    .TX_READY    (tx_ready),
    .TX_DONE     (tx_done),
    .TX_ERROR    (tx_error),
    .BUSY        (busy),
    .PS2_CLK_IN  (clk_line),
    .PS2_DATA_IN (data_line),
    .PS2_CLK_OE  (clk_oe),
    .PS2_DATA_OE (data_oe),
    .STATE       (state_dbg)
`ifdef PS2_TX_RETRY_EN
    ,
    .RETRY_COUNT (retry_count)
`endif
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Result monitor: every TX_DONE/TX_ERROR pulse must match the next expected result.
  always @(negedge clk) begin
    if (tx_done || tx_error) begin
      if (exp_res_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got done=%0b error=%0b expected none", tx_done, tx_error);
      end else begin
        check("result_pulse", {30'd0, tx_error, tx_done}, {30'd0, exp_res_q.pop_front()});
        check("busy_falls_with_pulse", {30'd0, busy_prev, busy}, 32'b10);
      end
    end
    busy_prev = busy;
  end

  // Driver: hand a byte over and check the start-bit latency.
  task automatic send(input logic [7:0] b);
    int w;
    w = 0;
    while (!tx_ready && w < 2000) begin @(negedge clk); w++; end
    check("ready_before_send", {31'd0, tx_ready}, 32'd1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    w = 0;
    while (!data_oe && w < INH + 10) begin @(negedge clk); w++; end
    check("start_bit_latency", w, INH - 1);
    check("clk_inhibit", {31'd0, clk_oe}, 32'd1);
  endtask

  // Keyboard model: waits for clock release with the start bit, then clocks.
  task automatic dev_frame(input logic ack, input int falls);
    logic [10:0] got;
    int w;
    got = '0;
    w = 0;
    while ((clk_oe || !data_oe) && w < 5000) begin @(negedge clk); w++; end
    check("release_with_start", {30'd0, clk_oe, data_oe}, 32'b01);
    repeat (30) @(negedge clk);
    got[0] = data_line;
    for (int i = 1; i <= 10 && i <= falls; i++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      got[i] = data_line;
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    if (falls >= 11) begin
      if (exp_frame_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL frame_unexpected: got=%0h expected none", got);
      end else begin
        check("frame_bits", {21'd0, got}, {21'd0, exp_frame_q.pop_front()});
      end
      dev_data_low = ack;
      repeat (2) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (5) @(negedge clk);
      dev_data_low = 1'b0;
      repeat (HALF) @(negedge clk);
    end
  endtask

  task automatic good_frame(input logic [7:0] b, input logic [10:0] fr);
    exp_frame_q.push_back(fr);
    exp_res_q.push_back(RES_DONE);
    send(b);
    dev_frame(1'b1, 11);
  endtask

  initial begin
    int c;
    logic busy_seen;
    reset        = 1'b1;
    tx_data      = 8'h00;
    tx_valid     = 1'b0;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready", {31'd0, tx_ready}, 32'd0);
    check("reset_outputs", {27'd0, tx_done, tx_error, busy, clk_oe, data_oe}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {31'd0, tx_ready}, 32'd1);
    check("idle_state", {29'd0, state_dbg}, {29'd0, ST_IDLE});

    good_frame(CMD_SET_LEDS, FR_ED);
    good_frame(8'h07, FR_07);
    good_frame(8'h00, FR_00);

    // NACK: keyboard leaves data high on clock 11
    for (int a = 0; a < ATTEMPTS; a++) exp_frame_q.push_back(FR_01);
    exp_res_q.push_back(RES_ERR);
    send(8'h01);
    for (int a = 0; a < ATTEMPTS; a++) dev_frame(1'b0, 11);
    check("idle_after_nack", {31'd0, busy}, 32'd0);
`ifdef PS2_TX_RETRY_EN
    check("retry_count_after_nack", {30'd0, retry_count}, 32'd2);
`endif

    // Timeout: keyboard never clocks
    exp_res_q.push_back(RES_ERR);
    send(CMD_RESET);
    c = 0;
    for (int a = 0; a < ATTEMPTS; a++) begin
      int w;
      w = 0;
      while ((clk_oe || !data_oe) && w < INH + 10) begin @(negedge clk); w++; end
      c = 0;
      while (!tx_error && !clk_oe && c < TMO + 50) begin @(negedge clk); c++; end
    end
    check("timeout_seen", {31'd0, tx_error}, 32'd1);
    check("timeout_cycles", c, TMO);
    check("oes_after_timeout", {30'd0, clk_oe, data_oe}, 32'd0);
    repeat (5) @(negedge clk);

    // Keyboard holds clock low: no accept
    dev_clk_low = 1'b1;
    repeat (20) @(negedge clk);
    check("ready_clk_low", {31'd0, tx_ready}, 32'd0);
    busy_seen = 1'b0;
    tx_data  = CMD_ECHO;
    tx_valid = 1'b1;
    repeat (5) begin @(negedge clk); busy_seen |= busy | clk_oe; end
    tx_valid = 1'b0;
    repeat (3) begin @(negedge clk); busy_seen |= busy | clk_oe; end
    check("no_accept_clk_low", {31'd0, busy_seen}, 32'd0);
    dev_clk_low = 1'b0;
    repeat (20) @(negedge clk);

    // Reset while bit 4 is on the line
    send(8'hA5);
    dev_frame(1'b1, 5);
    check("shift_before_reset", {29'd0, state_dbg}, {29'd0, ST_SHIFT});
    reset = 1'b1;
    @(negedge clk);
    check("reset_midframe", {28'd0, clk_oe, data_oe, busy, tx_done | tx_error}, 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    good_frame(CMD_ECHO, FR_EE);

    repeat (50) @(negedge clk);
    check("results_drained", exp_res_q.size(), 0);
    check("frames_drained", exp_frame_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
